fp_addsub_pipe: RTL and testbench
=================================

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width; word width W = 1+EXP_W+MAN_W (default 32, IEEE-754 single).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  W  operand A, IEEE format.
REQ-008 SHALL have port b  input  W  operand B, IEEE format.
REQ-009 SHALL have port op_sub  input  1  0: A+B; 1: A-B (B sign inverted).
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  W  rounded sum.
REQ-013 SHALL have port flags  output  4  {invalid, overflow, underflow, inexact}, aligned with result.

Function
REQ-014 SHALL be a 3-stage pipeline: S1 unpack/compare/swap/align; S2 mantissa add/subtract; S3 normalise/round/pack.
REQ-015 SHALL have a latency of exactly 3 cycles from accepted input to out_valid with no back-pressure; throughput 1 per cycle.
REQ-016 SHALL define global advance en = !out_valid || out_ready; in_ready = en; input accepted when in_valid && in_ready.
REQ-017 SHALL freeze every stage register, including valid bits, when en = 0; result and flags stable while out_valid && !out_ready.
REQ-018 SHALL propagate bubbles (valid = 0) through stages; stage data with valid = 0 is don't-care.
REQ-019 SHALL align the smaller-magnitude operand by right shift with guard, round and sticky bits; shifts >= MAN_W+3 collapse to sticky only.
REQ-020 SHALL for effective subtraction produce a magnitude result with the sign of the larger operand; leading-zero count drives left normalisation.
REQ-021 SHALL round to nearest, ties to even; mantissa carry-out from rounding increments the exponent.
REQ-022 SHALL flush subnormal inputs to signed zero and subnormal or too-small results to signed zero with underflow=1, inexact=1.
REQ-023 SHALL output +Inf/-Inf with overflow=1, inexact=1 when the rounded exponent reaches all-ones.
REQ-024 SHALL output canonical quiet NaN (sign 0, exponent all-ones, fraction MSB 1, rest 0; 0x7FC00000 at default) for any NaN input (invalid=0 unless signalling) or Inf minus Inf (invalid=1).
REQ-025 SHALL pass Inf +/- finite as the Inf with flags 0.
REQ-026 SHALL give exact cancellation +0; (-0)+(-0) = -0; (+0)+(-0) = +0.
REQ-027 SHALL set inexact whenever any of guard/round/sticky was non-zero before rounding.

Reset
REQ-028 SHALL clear all stage valid bits on rst: out_valid=0, in_ready=1 the cycle after reset asserts; result=0, flags=0.
REQ-029 SHALL discard all in-flight operations when reset is asserted mid-operation; no partial result emerges afterwards.
REQ-030 SHALL ignore inputs in any cycle rst is high.

Structure
REQ-031 SHALL place field-width localparams, canonical-NaN constant, flag bit indices and the unpacked-operand struct in package fp_pkg.
REQ-032 SHALL implement the leading-zero counter as sub-module fp_lzc, parameterised on width, combinational.
REQ-033 SHALL be 120-400 lines of RTL excluding package.

Verification
REQ-034 SHALL check a=0x44000000 (512), b=0x41B40000 (22.5), add -> result 0x4405A000 (534.5), flags 0, out_valid exactly 3 cycles after accept.
REQ-035 SHALL check a=0x44000000, b=0x44000000, op_sub=1 -> 0x00000000; and a=0x80000000, b=0x80000000 add -> 0x80000000.
REQ-036 SHALL check a=0x7F800000, b=0xFF800000 add -> 0x7FC00000, invalid=1; a=0x7F7FFFFF, b=0x7F7FFFFF add -> 0x7F800000, overflow=1, inexact=1.
REQ-037 SHALL check a=0x3F800000, b=0x33800000 (tie) -> 0x3F800000, inexact=1; b=0x33C00000 -> 0x3F800001, inexact=1.
REQ-038 SHALL check back-pressure: stream 8 operand pairs back-to-back, hold out_ready=0 for 5 cycles mid-stream -> in_ready drops, no result lost, duplicated or reordered.
REQ-039 SHALL check rst asserted with 3 operations in flight -> out_valid stays 0, next accepted operation returns correct result after 3 cycles.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared field widths, flag positions and operand classification for the FP adder.
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;

  localparam logic [FP_W-1:0] FP_QNAN =
    {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_MAN_W-1){1'b0}}};

  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  typedef struct packed {
    logic sign;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_snan;
  } fp_unpk_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero word returns W.
module fp_lzc #(
  parameter  int W  = 28,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  value,
  output logic [CW-1:0] count
);

  logic found;

  always_comb begin
    count = CW'(W);
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = CW'(W - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 adder/subtractor, round-to-nearest-even, subnormals flushed.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W = FP_EXP_W,
  parameter  int MAN_W = FP_MAN_W,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int STAGES = 3;
  localparam int SW     = MAN_W + 4;
  localparam int NW     = SW + 1;
  localparam int LZW    = $clog2(NW + 1);
  localparam int EW     = EXP_W + 2;

  localparam logic [W-1:0]         QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0] E_INF  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);

  function automatic logic [MAN_W+1:0] round_rne(input logic [MAN_W:0] sig, input logic g,
                                                 input logic r, input logic s);
    logic up;
    up = g & (r | s | sig[0]);
    return {1'b0, sig} + {{(MAN_W+1){1'b0}}, up};
  endfunction

  function automatic logic [W+3:0] sat_pack(input logic sign, input logic signed [EW-1:0] e,
                                            input logic [MAN_W-1:0] frac, input logic inexact);
    logic [3:0]   f;
    logic [W-1:0] w;
    f = '0;
    if (e >= E_INF) begin
      w = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      f[FLG_OVERFLOW] = 1'b1;
      f[FLG_INEXACT]  = 1'b1;
    end else if (e <= E_ZERO) begin
      w = {sign, {(W-1){1'b0}}};
      f[FLG_UNDERFLOW] = 1'b1;
      f[FLG_INEXACT]   = 1'b1;
    end else begin
      w = {sign, e[EXP_W-1:0], frac};
      f[FLG_INEXACT] = inexact;
    end
    return {f, w};
  endfunction

  logic en;
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;

  // ---- S1: unpack, classify, order by magnitude, align smaller operand ----
  logic [EXP_W-1:0]       exp_a, exp_b, ex, ey, diff;
  logic [MAN_W-1:0]       frc_a, frc_b;
  logic [EXP_W+MAN_W-1:0] mag_a, mag_b;
  logic [MAN_W:0]         sig_a, sig_b, sig_x, sig_y;
  logic [SW-1:0]          ext_y, mx_s1, my_s1;
  fp_unpk_t               ua, ub;
  logic                   swap, sx, lost, spc_s1;
  logic [W-1:0]           spc_res_s1;
  logic [3:0]             spc_flg_s1;

  always_comb begin
    exp_a      = a[W-2 -: EXP_W];
    exp_b      = b[W-2 -: EXP_W];
    frc_a      = a[MAN_W-1:0];
    frc_b      = b[MAN_W-1:0];
    ua.sign    = a[W-1];
    ua.is_zero = (exp_a == '0);
    ua.is_inf  = (&exp_a) && (frc_a == '0);
    ua.is_nan  = (&exp_a) && (frc_a != '0);
    ua.is_snan = ua.is_nan && !frc_a[MAN_W-1];
    ub.sign    = b[W-1] ^ op_sub;
    ub.is_zero = (exp_b == '0);
    ub.is_inf  = (&exp_b) && (frc_b == '0);
    ub.is_nan  = (&exp_b) && (frc_b != '0);
    ub.is_snan = ub.is_nan && !frc_b[MAN_W-1];
    mag_a      = ua.is_zero ? '0 : {exp_a, frc_a};
    mag_b      = ub.is_zero ? '0 : {exp_b, frc_b};
    sig_a      = ua.is_zero ? '0 : {1'b1, frc_a};
    sig_b      = ub.is_zero ? '0 : {1'b1, frc_b};
    swap       = mag_b > mag_a;
    sx         = swap ? ub.sign : ua.sign;
    ex         = swap ? exp_b : exp_a;
    ey         = swap ? exp_a : exp_b;
    sig_x      = swap ? sig_b : sig_a;
    sig_y      = swap ? sig_a : sig_b;
    diff       = ex - ey;
    mx_s1      = {sig_x, 3'b000};
    ext_y      = {sig_y, 3'b000};
    lost       = |(ext_y & ~({SW{1'b1}} << diff));
    if (int'(diff) >= MAN_W + 3)
      my_s1 = {{(SW-1){1'b0}}, |sig_y};
    else
      my_s1 = (ext_y >> diff) | {{(SW-1){1'b0}}, lost};

    spc_s1     = 1'b1;
    spc_res_s1 = '0;
    spc_flg_s1 = '0;
    if (ua.is_nan || ub.is_nan) begin
      spc_res_s1              = QNAN;
      spc_flg_s1[FLG_INVALID] = ua.is_snan | ub.is_snan;
    end else if (ua.is_inf && ub.is_inf && (ua.sign != ub.sign)) begin
      spc_res_s1              = QNAN;
      spc_flg_s1[FLG_INVALID] = 1'b1;
    end else if (ua.is_inf) begin
      spc_res_s1 = {ua.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ub.is_inf) begin
      spc_res_s1 = {ub.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ua.is_zero && ub.is_zero) begin
      spc_res_s1 = {ua.sign & ub.sign, {(W-1){1'b0}}};
    end else begin
      spc_s1 = 1'b0;
    end
  end

  logic             vld_p0, sgn_p0, sub_p0, spc_p0;
  logic [EXP_W-1:0] exp_p0;
  logic [SW-1:0]    mx_p0, my_p0;
  logic [W-1:0]     spc_res_p0;
  logic [3:0]       spc_flg_p0;

  // ---- S2: magnitude add or subtract (larger minus smaller, never negative) ----
  logic [NW-1:0] sum_s2;
  assign sum_s2 = sub_p0 ? ({1'b0, mx_p0} - {1'b0, my_p0}) : ({1'b0, mx_p0} + {1'b0, my_p0});

  logic             vld_p1, sgn_p1, spc_p1;
  logic [EXP_W-1:0] exp_p1;
  logic [NW-1:0]    sum_p1;
  logic [W-1:0]     spc_res_p1;
  logic [3:0]       spc_flg_p1;

  // ---- S3: normalise, round, saturate, pack ----
  logic [LZW-1:0]         lz;
  logic [NW-1:0]          norm;
  logic [MAN_W-1:0]       frac_n;
  logic [MAN_W+1:0]       rsig;
  logic signed [EW-1:0]   e_norm, e_rnd;
  logic                   g, r, s;
  logic [W+3:0]           packed_s3;
  logic [W-1:0]           res_s3;
  logic [3:0]             flg_s3;

  fp_lzc #(.W(NW)) u_lzc (.value(sum_p1), .count(lz));

  always_comb begin
    norm      = sum_p1 << lz;
    frac_n    = norm[NW-2 -: MAN_W];
    g         = norm[3];
    r         = norm[2];
    s         = |norm[1:0];
    e_norm    = $signed({2'b00, exp_p1}) + E_ONE - $signed({{(EW-LZW){1'b0}}, lz});
    rsig      = round_rne({1'b1, frac_n}, g, r, s);
    e_rnd     = e_norm + $signed({{(EW-1){1'b0}}, rsig[MAN_W+1]});
    packed_s3 = sat_pack(sgn_p1, e_rnd, rsig[MAN_W-1:0], g | r | s);
    if (spc_p1) begin
      res_s3 = spc_res_p1;
      flg_s3 = spc_flg_p1;
    end else if (sum_p1 == '0) begin
      res_s3 = '0;
      flg_s3 = '0;
    end else begin
      res_s3 = packed_s3[W-1:0];
      flg_s3 = packed_s3[W+3:W];
    end
  end

  logic         vld_p2;
  logic [W-1:0] result_p2;
  logic [3:0]   flags_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      flags_p2  <= '0;
    end else if (en) begin
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
      result_p2 <= res_s3;
      flags_p2  <= flg_s3;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      sgn_p0     <= sx;
      sub_p0     <= ua.sign ^ ub.sign;
      exp_p0     <= ex;
      mx_p0      <= mx_s1;
      my_p0      <= my_s1;
      spc_p0     <= spc_s1;
      spc_res_p0 <= spc_res_s1;
      spc_flg_p0 <= spc_flg_s1;
      sgn_p1     <= sgn_p0;
      exp_p1     <= exp_p0;
      sum_p1     <= sum_s2;
      spc_p1     <= spc_p0;
      spc_res_p1 <= spc_res_p0;
      spc_flg_p1 <= spc_flg_p0;
    end
  end

  assign out_valid = vld_p2;
  assign result    = result_p2;
  assign flags     = flags_p2;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: directed vectors, back-pressure, reset flush.
module tb_fp_addsub_pipe;
  import fp_pkg::*;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [FP_W-1:0] a, b, result;
  logic [3:0]      flags;

  typedef struct {
    logic [FP_W-1:0] res;
    logic [3:0]      flg;
    int              issue;
    bit              lat;
    string           name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  fp_addsub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish, cyc=%0d required <10000", cyc);
    $fatal(1);
  end

  // monitor: pop and compare on every output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output result=%h flags=%b required none", result, flags);
      end else begin
        mon_e = sb_q.pop_front();
        checks++;
        if (result !== mon_e.res) begin
          errors++;
          $display("FAIL %s result got %h required %h", mon_e.name, result, mon_e.res);
        end
        checks++;
        if (flags !== mon_e.flg) begin
          errors++;
          $display("FAIL %s flags got %b required %b", mon_e.name, flags, mon_e.flg);
        end
        if (mon_e.lat) begin
          checks++;
          if (cyc - mon_e.issue != 3) begin
            errors++;
            $display("FAIL %s latency got %0d required 3", mon_e.name, cyc - mon_e.issue);
          end
        end
      end
    end
  end

  task automatic send(input string nm, input logic [FP_W-1:0] ta, input logic [FP_W-1:0] tb_v,
                      input logic top, input logic [FP_W-1:0] er, input logic [3:0] ef,
                      input bit lat, input bit push);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    a = ta;
    b = tb_v;
    op_sub = top;
    in_valid = 1'b1;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s accept_timeout in_ready=%b required 1", nm, in_ready);
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      e.res   = er;
      e.flg   = ef;
      e.issue = cyc;
      e.lat   = lat;
      e.name  = nm;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_bit(input string nm, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %b required %b", nm, got, req);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    op_sub = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b1);
    checks++;
    if (result !== '0 || flags !== 4'b0000) begin
      errors++;
      $display("FAIL rst_result got %h/%b required 00000000/0000", result, flags);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    send("add_512_22p5", 32'h44000000, 32'h41B40000, 1'b0, 32'h4405A000, 4'b0000, 1'b1, 1'b1);
    drain();
    send("sub_cancel",   32'h44000000, 32'h44000000, 1'b1, 32'h00000000, 4'b0000, 1'b1, 1'b1);
    send("neg0_neg0",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 1'b1, 1'b1);
    send("pos0_neg0",    32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000, 1'b1, 1'b1);
    send("inf_m_inf",    32'h7F800000, 32'hFF800000, 1'b0, FP_QNAN,      4'b1000, 1'b1, 1'b1);
    send("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 1'b1, 1'b1);
    send("tie_even",     32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 1'b1, 1'b1);
    send("above_tie",    32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001, 1'b1, 1'b1);
    send("qnan_in",      32'h7FC00001, 32'h3F800000, 1'b0, FP_QNAN,      4'b0000, 1'b1, 1'b1);
    send("snan_in",      32'h7F800001, 32'h3F800000, 1'b0, FP_QNAN,      4'b1000, 1'b1, 1'b1);
    send("inf_p_fin",    32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 1'b1, 1'b1);
    send("underflow",    32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011, 1'b1, 1'b1);
    send("subnorm_in",   32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, 1'b1, 1'b1);
    drain();

    fork
      begin
        send("bp0", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 1'b0, 1'b1);
        send("bp1", 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'b0000, 1'b0, 1'b1);
        send("bp2", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 1'b0, 1'b1);
        send("bp3", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, 1'b0, 1'b1);
        send("bp4", 32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000, 4'b0000, 1'b0, 1'b1);
        send("bp5", 32'h3F000000, 32'h3E800000, 1'b0, 32'h3F400000, 4'b0000, 1'b0, 1'b1);
        send("bp6", 32'h41200000, 32'hC0800000, 1'b0, 32'h40C00000, 4'b0000, 1'b0, 1'b1);
        send("bp7", 32'h42C80000, 32'h3F000000, 1'b1, 32'h42C70000, 4'b0000, 1'b0, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_bit("bp_in_ready_low", in_ready, 1'b0);
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    @(negedge clk);
    out_ready = 1'b0;
    send("flush0", 32'h3F800000, 32'h3F800000, 1'b0, '0, 4'b0000, 1'b0, 1'b0);
    send("flush1", 32'h40000000, 32'h40000000, 1'b0, '0, 4'b0000, 1'b0, 1'b0);
    send("flush2", 32'h40400000, 32'h40400000, 1'b0, '0, 4'b0000, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_bit("post_rst_out_valid", out_valid, 1'b0);
    end
    send("after_rst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 1'b1, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
